// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder with start/busy/done handshake
//
// Purpose:
//    Adds two unsigned WIDTH-bit operands plus a carry-in, one bit per clock,
//    LSB first. The per-bit full adder is two half_adder slices and an OR.
//    A carry flip-flop links consecutive bits.
//
// Modules in this file:
//    half_adder   - single-bit half adder (s = a ^ b, c = a & b)
//    serial_adder - top level
//
// serial_adder ports:
//    clk    in   system clock, rising edge
//    rst_n  in   asynchronous active-low reset
//    start  in   request; accepted in IDLE or DONE, ignored while busy
//    a, b   in   WIDTH-bit operands, captured when start is accepted
//    cin    in   carry-in, captured when start is accepted
//    busy   out  high while bits are being shifted
//    done   out  one-cycle pulse when sum/cout become valid
//    sum    out  WIDTH-bit registered result, held until next completion
//    cout   out  registered carry-out, held like sum
//    ovf    out  signed overflow (only with SERIAL_ADDER_OVF_EN defined)
//
// Build option:
//    SERIAL_ADDER_OVF_EN - adds the ovf output and its latch.

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   // Counter needs at least one bit so WIDTH=1 still has a legal vector.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;
   logic             carry;

   logic s0, c0, s1, c1;
   logic carry_new;
   logic accept;
   logic last_bit;

   // Full-adder slice on the current LSBs.
   half_adder u_ha0 (
      .a (opa[0]),
      .b (opb[0]),
      .s (s0),
      .c (c0)
   );

   half_adder u_ha1 (
      .a (s0),
      .b (carry),
      .s (s1),
      .c (c1)
   );

   assign carry_new = c0 | c1;

   // New bit enters at the MSB; after WIDTH shifts bit 0 of the first step
   // has reached res[0]. Shifting the concatenation keeps WIDTH=1 legal.
   assign res_next = WIDTH'({s1, res} >> 1);

   // start is honoured in IDLE and in the DONE cycle (back-to-back mode).
   assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_bit = (state_q == SHIFT) && (cnt == LAST);

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = accept ? SHIFT : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else if (accept) begin
         opa   <= a;
         opb   <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state_q == SHIFT) begin
         opa   <= opa >> 1;
         opb   <= opb >> 1;
         res   <= res_next;
         carry <= carry_new;
         cnt   <= cnt + 1'b1;
         if (last_bit) begin
            sum  <= res_next;
            cout <= carry_new;
`ifdef SERIAL_ADDER_OVF_EN
            // On the last bit, carry holds the carry into the MSB.
            ovf  <= carry ^ carry_new;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder

module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Single start pulse, then count busy cycles until done (bounded).
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                         input logic tc, input logic [7:0] es, input logic ec);
      int n;
      logic busy_ok;
      @(negedge clk);
      a = ta; b = tbv; cin = tc; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (done) break;
         if (!busy) busy_ok = 1'b0;
         n++;
         if (n > 40) break;
      end
      check({tag, "_lat"}, n, 8);
      check({tag, "_busy"}, busy_ok, 1);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
   endtask

   initial begin
      int n;
      int dones;

      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
      run_op("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("allones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      run_op("cinonly", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
      run_op("alt", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

      // Start during busy must be ignored.
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            check("ign_sum", sum, 8'h46);
            check("ign_cout", cout, 0);
         end
      end
      check("ign_dones", dones, 1);

      // Back-to-back with start held high.
      @(negedge clk);
      a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done", done, 1);
      check("b2b_sum1", sum, 8'h03);
      a = 8'h10; b = 8'h20;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      start = 1'b0;
      check("b2b_gap", n, 9);
      check("b2b_sum2", sum, 8'h30);
      check("b2b_cout2", cout, 0);
      @(negedge clk);
      check("b2b_idle", {busy, done}, 2'b00);

      // Reset in the middle of an operation.
      @(negedge clk);
      a = 8'hF0; b = 8'h0F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      check("mrst_sum", sum, 0);
      check("mrst_cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      check("mrst_quiet", dones, 0);
      run_op("after_rst", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
      run_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      check("ovf_pos_ovf", ovf, 1);
      run_op("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      check("ovf_neg_ovf", ovf, 1);
      run_op("ovf_none", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
      check("ovf_none_ovf", ovf, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
